// File: rtl/median_filter_frame_ctrl.sv
// Frame sequencer for the 2x2 median filter: streams a source frame in, compacts filtered pixels out.
// Latency: first source read one cycle after filt_start_o; done_o one cycle after the completing write.
// Backpressure: none downstream; source issue rate throttled by issue_gap_i. Optional perf counters: MEDIAN_FRAME_CTRL_PERF_EN.
module median_filter_frame_ctrl #(
    parameter int IMAGE_LEN     = 1080,
    parameter int IMAGE_HEIGHT  = 720,
    parameter int DRAIN_TIMEOUT = 64,
    parameter int SRC_AW        = $clog2(IMAGE_LEN*IMAGE_HEIGHT),
    parameter int DST_AW        = $clog2((IMAGE_LEN-1)*(IMAGE_HEIGHT-1))
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [3:0]        issue_gap_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              src_rd_en_o,
    output logic [SRC_AW-1:0] src_addr_o,
    input  logic [23:0]       src_data_i,
    output logic              filt_start_o,
    output logic [24:0]       pixel_valid_if_o,
    input  logic [24:0]       pixel_valid_if_i,
    input  logic              filt_done_i,
    output logic              dst_wr_en_o,
    output logic [DST_AW-1:0] dst_addr_o,
    output logic [23:0]       dst_data_o
`ifdef MEDIAN_FRAME_CTRL_PERF_EN
    ,
    output logic [31:0]       frame_cycles_o,
    output logic [SRC_AW:0]   in_beats_o
`endif
);

    // Pixel bus packing: bit 24 is valid, bits 23:0 are {R,G,B}.
    localparam int WCW = DST_AW + 1;
    localparam int DCW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [SRC_AW-1:0] RD_LAST    = SRC_AW'(IMAGE_LEN*IMAGE_HEIGHT - 1);
    localparam logic [WCW-1:0]    N_OUT      = WCW'((IMAGE_LEN-1)*(IMAGE_HEIGHT-1));
    localparam logic [DCW-1:0]    DRAIN_LAST = DCW'(DRAIN_TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_FEED  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [3:0]        gap_q, gap_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    logic [SRC_AW-1:0] rd_cnt_q, rd_cnt_d;
    logic [WCW-1:0]    wr_cnt_q, wr_cnt_d;
    logic [DCW-1:0]    drain_cnt_q, drain_cnt_d;
    logic              fdone_seen_q, fdone_seen_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              pix_vld_q;
    logic              rd_en, wr_en, in_act, fwd_vld;

    // Capture is only meaningful while a frame is streaming or draining.
    assign in_act  = (state_q == ST_FEED) || (state_q == ST_DRAIN);
    // An abort kills the read already in flight so the filter never sees a partial tail.
    assign fwd_vld = pix_vld_q && !abort_i;

    // Next-state, read issue, write capture and completion/timeout decisions.
    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        gap_cnt_d    = gap_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        fdone_seen_d = fdone_seen_q;
        done_d       = 1'b0;
        err_d        = err_q;
        rd_en        = 1'b0;
        wr_en        = in_act && pixel_valid_if_i[24] && !abort_i;

        if (wr_en) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
        if (in_act && filt_done_i) begin
            fdone_seen_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d      = ST_ARM;
                    gap_d        = issue_gap_i;
                    err_d        = 1'b0;
                    gap_cnt_d    = 4'd0;
                    rd_cnt_d     = '0;
                    wr_cnt_d     = '0;
                    drain_cnt_d  = '0;
                    fdone_seen_d = 1'b0;
                end
            end
            ST_ARM: begin
                state_d = ST_FEED;
            end
            ST_FEED: begin
                if (gap_cnt_q == 4'd0) begin
                    rd_en     = 1'b1;
                    gap_cnt_d = gap_q;
                    if (rd_cnt_q == RD_LAST) begin
                        // Hold the counter on the last address rather than wrapping.
                        state_d     = ST_DRAIN;
                        drain_cnt_d = '0;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                // The write landing this cycle counts toward completion.
                if ((fdone_seen_q || filt_done_i) && (wr_cnt_d == N_OUT)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
        endcase

        if (abort_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            rd_en   = 1'b0;
            done_d  = 1'b0;
            err_d   = err_q;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gap_q        <= 4'd0;
            gap_cnt_q    <= 4'd0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            drain_cnt_q  <= '0;
            fdone_seen_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            pix_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            gap_cnt_q    <= gap_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            fdone_seen_q <= fdone_seen_d;
            done_q       <= done_d;
            err_q        <= err_d;
            pix_vld_q    <= rd_en;
        end
    end

    assign busy_o           = (state_q != ST_IDLE);
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign src_rd_en_o      = rd_en;
    assign src_addr_o       = rd_cnt_q;
    assign filt_start_o     = (state_q == ST_ARM);
    assign pixel_valid_if_o = {fwd_vld, fwd_vld ? src_data_i : 24'h0};
    assign dst_wr_en_o      = wr_en;
    assign dst_addr_o       = wr_cnt_q[DST_AW-1:0];
    assign dst_data_o       = wr_en ? pixel_valid_if_i[23:0] : 24'h0;

`ifdef MEDIAN_FRAME_CTRL_PERF_EN
    logic [31:0]     cyc_q, frame_cycles_q;
    logic [SRC_AW:0] beat_q, in_beats_q;
    logic [31:0]     cyc_inc;

    assign cyc_inc = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;

    // Frame cycle and input beat counters; results published alongside done_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q          <= 32'd0;
            beat_q         <= '0;
            frame_cycles_q <= 32'd0;
            in_beats_q     <= '0;
        end else begin
            if ((state_q == ST_IDLE) && start_i) begin
                cyc_q  <= 32'd0;
                beat_q <= '0;
            end else if (busy_o) begin
                cyc_q  <= cyc_inc;
                beat_q <= beat_q + {{SRC_AW{1'b0}}, fwd_vld};
            end
            if (done_d) begin
                frame_cycles_q <= cyc_inc;
                in_beats_q     <= beat_q + {{SRC_AW{1'b0}}, fwd_vld};
            end
        end
    end

    assign frame_cycles_o = frame_cycles_q;
    assign in_beats_o     = in_beats_q;
`endif

endmodule
